// File: rtl/mmio_uart_bridge.sv
// Data-bus decoder: a 4 KiB MMIO window holds a UART TX FIFO, status and RX sample registers.
// Optional CLINT-style mtime/mtimecmp timer is built when MMIO_CLINT_EN is defined.
module mmio_uart_bridge #(
  parameter logic [63:0] UART_BASE  = 64'h0000_0000_1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_en,
  input  logic [7:0]  cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic [63:0] cpu_rdata,
  output logic        sram_en,
  output logic [7:0]  sram_we,
  output logic [63:0] sram_addr,
  output logic [63:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        tx_ready,
  output logic        uart_out_valid,
  output logic [7:0]  uart_out_ch,
  output logic        uart_in_valid,
  input  logic [7:0]  uart_in_ch,
  output logic        timer_int
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic          hit;
  logic          is_rd;
  logic [8:0]    idx;
  logic          sel_mmio;
  logic [63:0]   mmio_rd;
  logic [63:0]   mmio_rdata_q;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          ovf;
  logic          ovf_set;
  logic          ovf_clr;

  assign hit   = cpu_en & (cpu_addr[63:12] == UART_BASE[63:12]);
  assign idx   = cpu_addr[11:3];
  assign is_rd = hit & (cpu_we == 8'h00);

  assign sram_en    = cpu_en & ~hit;
  assign sram_we    = hit ? 8'h00 : cpu_we;
  assign sram_addr  = cpu_addr;
  assign sram_wdata = cpu_wdata;

  assign cpu_rdata     = sel_mmio ? mmio_rdata_q : sram_rdata;
  assign uart_in_valid = is_rd & (idx == 9'd2);

  // uart_out: one character transfers on every cycle uart_out_valid is high;
  // tx_ready, sampled in the cycle before, is the only back-pressure.
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop      = ~empty & tx_ready;
  assign push_req = hit & (idx == 9'd0) & cpu_we[0];
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & ~push_ok;
  assign ovf_clr  = hit & (idx == 9'd1) & cpu_we[0] & cpu_wdata[2];

`ifdef MMIO_CLINT_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  be);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_int <= 1'b0;
    end else begin
      timer_int <= (mtime >= mtimecmp);
      if (hit && idx == 9'd3 && cpu_we != 8'h00) mtime <= merge_bytes(mtime, cpu_wdata, cpu_we);
      else                                       mtime <= mtime + 64'd1;
      if (hit && idx == 9'd4) mtimecmp <= merge_bytes(mtimecmp, cpu_wdata, cpu_we);
    end
  end
`else
  assign timer_int = 1'b0;
`endif

  always_comb begin
    mmio_rd = '0;
    case (idx)
      9'd1:    mmio_rd = {61'd0, ovf, empty, full};
      9'd2:    mmio_rd = {56'd0, uart_in_ch};
`ifdef MMIO_CLINT_EN
      9'd3:    mmio_rd = mtime;
      9'd4:    mmio_rd = mtimecmp;
`endif
      default: mmio_rd = '0;
    endcase
  end

  // FIFO storage carries no reset; clearing the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= cpu_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      ovf            <= 1'b0;
      uart_out_valid <= 1'b0;
      uart_out_ch    <= '0;
      sel_mmio       <= 1'b0;
      mmio_rdata_q   <= '0;
    end else begin
      sel_mmio       <= hit;
      mmio_rdata_q   <= mmio_rd;
      uart_out_valid <= pop;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        uart_out_ch <= fifo_mem[rd_ptr];
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // An overflow in the same cycle as a clear keeps the flag set.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Bench for mmio_uart_bridge: queue-based model checked every cycle, plus directed literal checks.
module tb_mmio_uart_bridge;
  localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
  localparam int          DEPTH = 8;

  logic        clk, rst_n;
  logic        cpu_en;
  logic [7:0]  cpu_we;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        sram_en;
  logic [7:0]  sram_we;
  logic [63:0] sram_addr, sram_wdata, sram_rdata;
  logic        tx_ready, uart_out_valid, uart_in_valid, timer_int;
  logic [7:0]  uart_out_ch, uart_in_ch;

  int checks   = 0;
  int failures = 0;

  logic       rdy_req;
  logic [7:0] ch_req;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  mmio_uart_bridge #(.UART_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .tx_ready(tx_ready), .uart_out_valid(uart_out_valid), .uart_out_ch(uart_out_ch),
    .uart_in_valid(uart_in_valid), .uart_in_ch(uart_in_ch), .timer_int(timer_int)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] fake_sram(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'hDEAD;
    return {a[31:0] ^ 32'hA5A5_5A5A, a[63:32]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM stand-in: read data one cycle after the address ----------------
  logic [63:0] prev_addr;
  always @(posedge clk) begin
    prev_addr  <= cpu_addr;
    sram_rdata <= fake_sram(cpu_addr);
  end

  // ---------------- behavioural model ----------------
  logic        m_hit, m_ovf;
  logic [8:0]  m_idx;
  int          m_size;
  logic [63:0] m_mtime, m_cmp;
  logic        exp_valid, exp_timer, exp_sel, exp_prev_rd;
  logic [7:0]  exp_ch;
  logic [63:0] exp_mmio;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ovf = 0; m_mtime = '0; m_cmp = '1;
      exp_valid = 0; exp_ch = '0; exp_timer = 0;
      exp_sel = 0; exp_prev_rd = 0; exp_mmio = '0;
    end else begin
      m_hit  = cpu_en && (cpu_addr[63:12] == BASE[63:12]);
      m_idx  = cpu_addr[11:3];
      m_size = exp_q.size();
      case (m_idx)
        9'd1:    exp_mmio = {61'd0, m_ovf, m_size == 0, m_size == DEPTH};
        9'd2:    exp_mmio = {56'd0, uart_in_ch};
`ifdef MMIO_CLINT_EN
        9'd3:    exp_mmio = m_mtime;
        9'd4:    exp_mmio = m_cmp;
`endif
        default: exp_mmio = '0;
      endcase
      exp_sel     = m_hit;
      exp_prev_rd = cpu_en && (cpu_we == 8'h00);
`ifdef MMIO_CLINT_EN
      exp_timer = (m_mtime >= m_cmp);
      if (m_hit && m_idx == 9'd3 && cpu_we != 8'h00) m_mtime = merge(m_mtime, cpu_wdata, cpu_we);
      else                                           m_mtime = m_mtime + 64'd1;
      if (m_hit && m_idx == 9'd4) m_cmp = merge(m_cmp, cpu_wdata, cpu_we);
`endif
      if (m_size != 0 && tx_ready) begin
        exp_valid = 1;
        exp_ch    = exp_q.pop_front();
      end else begin
        exp_valid = 0;
      end
      if (m_hit && m_idx == 9'd1 && cpu_we[0] && cpu_wdata[2]) m_ovf = 0;
      if (m_hit && m_idx == 9'd0 && cpu_we[0]) begin
        if (m_size < DEPTH || (m_size != 0 && tx_ready)) exp_q.push_back(cpu_wdata[7:0]);
        else m_ovf = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic c_hit;
  always @(negedge clk) begin
    #3;
    c_hit = cpu_en && (cpu_addr[63:12] == BASE[63:12]);
    chk("sram_en", 64'(sram_en), 64'(cpu_en && !c_hit));
    chk("sram_we", 64'(sram_we), 64'(c_hit ? 8'h00 : cpu_we));
    chk("sram_addr", sram_addr, cpu_addr);
    chk("sram_wdata", sram_wdata, cpu_wdata);
    chk("uart_in_valid", 64'(uart_in_valid),
        64'(c_hit && cpu_addr[11:3] == 9'd2 && cpu_we == 8'h00));
    chk("uart_out_valid", 64'(uart_out_valid), 64'(exp_valid));
    chk("uart_out_ch", 64'(uart_out_ch), 64'(exp_ch));
    chk("timer_int", 64'(timer_int), 64'(exp_timer));
    if (!exp_sel)         chk("rdata_sram", cpu_rdata, fake_sram(prev_addr));
    else if (exp_prev_rd) chk("rdata_mmio", cpu_rdata, exp_mmio);
    if (uart_out_valid) obs_q.push_back(uart_out_ch);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [7:0] we, input logic [63:0] addr,
                       input logic [63:0] wd);
    @(negedge clk);
    cpu_en = en; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    tx_ready = rdy_req; uart_in_ch = ch_req;
  endtask

  task automatic wr(input logic [11:0] off, input logic [63:0] d);
    drive(1'b1, 8'h01, BASE + 64'(off), d);
  endtask

  task automatic wr_be(input logic [11:0] off, input logic [63:0] d, input logic [7:0] be);
    drive(1'b1, be, BASE + 64'(off), d);
  endtask

  task automatic rd(input logic [11:0] off);
    drive(1'b1, 8'h00, BASE + 64'(off), {$urandom, $urandom});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic rd_expect(input string name, input logic [11:0] off, input logic [63:0] exp);
    rd(off);
    idle(1);
    #4;
    chk(name, cpu_rdata, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cpu_en = 1'b0; tx_ready = rdy_req;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          sel;
    logic [8:0]  ix;
    logic [63:0] a;
    rst_n = 0; cpu_en = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    tx_ready = 0; uart_in_ch = 0; rdy_req = 0; ch_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #4;
    chk("rst_valid", 64'(uart_out_valid), 64'd0);
    chk("rst_ch", 64'(uart_out_ch), 64'd0);
    chk("rst_timer", 64'(timer_int), 64'd0);
    rd_expect("rst_status", 12'h008, 64'h2);

    // three characters back to back, drained immediately
    rdy_req = 1; obs_q.delete();
    wr(12'h000, 64'h41);
    #4 chk("tx_sram_en", 64'(sram_en), 64'd0);
    wr(12'h000, 64'h42);
    wr(12'h000, 64'h43);
    #4;
    chk("tx_first_valid", 64'(uart_out_valid), 64'd1);
    chk("tx_first_ch", 64'(uart_out_ch), 64'h41);
    idle(5);
    chk("tx3_count", 64'(obs_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) if (i < obs_q.size()) chk("tx3_ch", 64'(obs_q[i]), 64'h41 + 64'(i));

    // overflow: nine pushes into eight entries
    rdy_req = 0; obs_q.delete();
    for (int i = 0; i < 9; i++) wr(12'h000, 64'h60 + 64'(i));
    rd_expect("ovf_status", 12'h008, 64'h5);
    wr(12'h008, 64'h4);
    rd_expect("ovf_cleared_status", 12'h008, 64'h1);
    rdy_req = 1;
    idle(12);
    chk("ovf_drain_count", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) if (i < obs_q.size()) chk("ovf_drain_ch", 64'(obs_q[i]), 64'h60 + 64'(i));
    rd_expect("drained_status", 12'h008, 64'h2);

    // full FIFO with a pop in the same cycle accepts the push
    rdy_req = 0; idle(2); obs_q.delete();
    for (int i = 0; i < 8; i++) wr(12'h000, 64'h70 + 64'(i));
    rdy_req = 1;
    wr(12'h000, 64'h78);
    rdy_req = 0;
    rd_expect("pop_push_status", 12'h008, 64'h1);
    rdy_req = 1;
    idle(12);
    chk("pop_push_count", 64'(obs_q.size()), 64'd9);
    for (int i = 0; i < 9; i++) if (i < obs_q.size()) chk("pop_push_ch", 64'(obs_q[i]), 64'h70 + 64'(i));

    // alternating SRAM / RXDATA reads
    rdy_req = 0; ch_req = 8'h5A;
    drive(1'b1, 8'h00, 64'h8000_0000, 64'd0);
    rd(12'h010);
    #4 chk("alt_sram0", cpu_rdata, 64'hDEAD);
    chk("alt_in_valid_rx", 64'(uart_in_valid), 64'd1);
    drive(1'b1, 8'h00, 64'h8000_0000, 64'd0);
    #4 chk("alt_rx0", cpu_rdata, 64'h5A);
    chk("alt_in_valid_sram", 64'(uart_in_valid), 64'd0);
    rd(12'h010);
    #4 chk("alt_sram1", cpu_rdata, 64'hDEAD);
    idle(1);
    #4 chk("alt_rx1", cpu_rdata, 64'h5A);

    // asynchronous reset mid-drain with an MMIO read in flight
    rdy_req = 0; obs_q.delete();
    for (int i = 0; i < 4; i++) wr(12'h000, 64'h30 + 64'(i));
    rdy_req = 1;
    rd(12'h008);
    @(negedge clk);
    rst_n = 0; cpu_en = 0;
    #3;
    chk("arst_valid", 64'(uart_out_valid), 64'd0);
    chk("arst_ch", 64'(uart_out_ch), 64'd0);
    chk("arst_rdata", cpu_rdata, fake_sram(BASE + 64'h8));
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle(10);
    chk("arst_no_stale", 64'(obs_q.size()), 64'd0);
    rd_expect("arst_status", 12'h008, 64'h2);

`ifdef MMIO_CLINT_EN
    do_reset();
    wr_be(12'h020, 64'd20, 8'hFF);
    rd_expect("cmp_readback", 12'h020, 64'd20);
    chk("timer_low", 64'(timer_int), 64'd0);
    idle(25);
    chk("timer_high", 64'(timer_int), 64'd1);
`else
    wr_be(12'h018, 64'hFFFF, 8'hFF);
    wr_be(12'h020, 64'h5, 8'hFF);
    rd_expect("mtime_absent", 12'h018, 64'd0);
    rd_expect("cmp_absent", 12'h020, 64'd0);
    chk("timer_tied", 64'(timer_int), 64'd0);
`endif

    // randomized traffic with bursts of back-pressure
    for (int n = 0; n < 3000; n++) begin
      rdy_req = ((n / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      ch_req  = 8'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        idle(1);
      end else if (sel < 6) begin
        ix = ($urandom_range(0, 2) == 0) ? 9'($urandom_range(1, 5)) : 9'd0;
        a  = BASE + {52'd0, ix, 3'($urandom)};
        drive(1'b1, ($urandom_range(0, 2) != 0) ? 8'($urandom) : 8'h00, a, {$urandom, $urandom});
      end else if (sel < 9) begin
        case ($urandom_range(0, 3))
          0:       a = BASE - 64'd8;
          1:       a = BASE + 64'h1000;
          2:       a = 64'h8000_0000;
          default: a = {$urandom, $urandom};
        endcase
        drive(1'b1, ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00, a, {$urandom, $urandom});
      end else begin
        a = BASE + {52'd0, 9'($urandom), 3'd0};
        drive(1'b1, 8'($urandom), a, {$urandom, $urandom});
      end
    end
    rdy_req = 1;
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
